// File: rtl/pe_result_pack.sv
// rtl/pe_result_pack.sv - packs a stream of 32-bit PE results into wide output lines
module pe_result_pack #(
    parameter int LANES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           base_addr,
    input  logic [15:0]           num_results,
    input  logic [31:0]           res_i,
    input  logic                  res_vld_i,
    output logic                  stall_o,
    output logic                  wr_en_o,
    output logic [15:0]           wr_addr_o,
    output logic [32*LANES-1:0]   wr_data_o,
    output logic [LANES-1:0]      wr_mask_o,
    input  logic                  wr_rdy_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_err_o
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DW = 32 * LANES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     num_q, num_d;
    logic [15:0]     addr_q, addr_d;
    logic [DW-1:0]   pack_data_q, pack_data_d;
    logic [LANES-1:0] pack_mask_q, pack_mask_d;
    logic            line_full_q, line_full_d;
    logic            wr_en_q, wr_en_d;
    logic [15:0]     wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [LANES-1:0] wr_mask_q, wr_mask_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;

    logic            accept;
    logic            drop;
    logic            drain;
    logic            buf_free;
    logic [15:0]     cnt_inc;
    logic            last_result;
    logic            lane_last;
    logic [DW-1:0]   upd_data;
    logic [LANES-1:0] upd_mask;

    // Next-state logic: result packing, output buffer hand-off and job sequencing
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        addr_d      = addr_q;
        pack_data_d = pack_data_q;
        pack_mask_d = pack_mask_q;
        line_full_d = line_full_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_mask_d   = wr_mask_q;
        ovf_d       = ovf_q;
        upd_data    = pack_data_q;
        upd_mask    = pack_mask_q;

        accept      = (state_q == COLLECT) && res_vld_i && !line_full_q;
        drop        = res_vld_i && !accept;
        drain       = wr_en_q && wr_rdy_i;
        buf_free    = !wr_en_q || drain;
        cnt_inc     = cnt_q + 16'd1;
        last_result = (cnt_inc == num_q);
        lane_last   = (lane_q == LW'(LANES - 1));

        // A drained buffer empties unless a new line is loaded below.
        if (drain) begin
            wr_en_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d       = 1'b0;
                    lane_d      = '0;
                    cnt_d       = '0;
                    pack_data_d = '0;
                    pack_mask_d = '0;
                    line_full_d = 1'b0;
                    addr_d      = base_addr;
                    num_d       = num_results;
                    state_d     = (num_results == 16'd0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                // A held line moves out as soon as the buffer frees.
                if (line_full_q && buf_free) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = addr_q;
                    wr_data_d   = pack_data_q;
                    wr_mask_d   = pack_mask_q;
                    addr_d      = addr_q + 16'd1;
                    pack_data_d = '0;
                    pack_mask_d = '0;
                    line_full_d = 1'b0;
                end
                if (accept) begin
                    upd_data[{lane_q, 5'b00000} +: 32] = res_i;
                    upd_mask[lane_q] = 1'b1;
                    cnt_d  = cnt_inc;
                    lane_d = lane_q + LW'(1);
                    if (lane_last || last_result) begin
                        lane_d = '0;
                        if (buf_free) begin
                            wr_en_d     = 1'b1;
                            wr_addr_d   = addr_q;
                            wr_data_d   = upd_data;
                            wr_mask_d   = upd_mask;
                            addr_d      = addr_q + 16'd1;
                            pack_data_d = '0;
                            pack_mask_d = '0;
                        end else begin
                            pack_data_d = upd_data;
                            pack_mask_d = upd_mask;
                            line_full_d = 1'b1;
                        end
                    end else begin
                        pack_data_d = upd_data;
                        pack_mask_d = upd_mask;
                    end
                    if (last_result) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (line_full_q && buf_free) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = addr_q;
                    wr_data_d   = pack_data_q;
                    wr_mask_d   = pack_mask_q;
                    addr_d      = addr_q + 16'd1;
                    pack_data_d = '0;
                    pack_mask_d = '0;
                    line_full_d = 1'b0;
                end
                // Finished once the last line leaves and nothing is waiting behind it.
                if (drain && !line_full_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (drop) begin
            ovf_d = 1'b1;
        end

        done_d = (state_d == DONE);
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            cnt_q       <= '0;
            num_q       <= '0;
            addr_q      <= '0;
            pack_data_q <= '0;
            pack_mask_q <= '0;
            line_full_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_mask_q   <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            addr_q      <= addr_d;
            pack_data_q <= pack_data_d;
            pack_mask_q <= pack_mask_d;
            line_full_q <= line_full_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_mask_q   <= wr_mask_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign stall_o   = line_full_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign wr_mask_o = wr_mask_q;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign ovf_err_o = ovf_q;

endmodule

// File: tb/tb_pe_result_pack.sv
// tb/tb_pe_result_pack.sv - directed scoreboard bench for pe_result_pack
module tb_pe_result_pack;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [15:0]  base_addr;
    logic [15:0]  num_results;
    logic [31:0]  res_i;
    logic         res_vld_i;
    logic         stall_o;
    logic         wr_en_o;
    logic [15:0]  wr_addr_o;
    logic [511:0] wr_data_o;
    logic [15:0]  wr_mask_o;
    logic         wr_rdy_i;
    logic         busy_o;
    logic         done_o;
    logic         ovf_err_o;

    typedef struct {
        logic [15:0]  addr;
        logic [511:0] data;
        logic [15:0]  mask;
    } line_t;

    line_t        sb[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           last_wr_cyc = -100;
    logic         held_prev = 1'b0;
    logic [15:0]  prev_addr;
    logic [511:0] prev_data;
    logic [15:0]  prev_mask;

    pe_result_pack #(.LANES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .num_results (num_results),
        .res_i       (res_i),
        .res_vld_i   (res_vld_i),
        .stall_o     (stall_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .wr_mask_o   (wr_mask_o),
        .wr_rdy_i    (wr_rdy_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ovf_err_o   (ovf_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: held outputs must not move; each accepted write pops the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            held_prev = 1'b0;
        end else begin
            if (held_prev) begin
                chk("hold_en", {511'd0, wr_en_o}, 512'd1);
                chk("hold_addr", {496'd0, wr_addr_o}, {496'd0, prev_addr});
                chk("hold_data", wr_data_o, prev_data);
                chk("hold_mask", {496'd0, wr_mask_o}, {496'd0, prev_mask});
            end
            if (wr_en_o && wr_rdy_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {496'd0, wr_addr_o}, 512'hDEAD_0000);
                end else begin
                    line_t e;
                    e = sb.pop_front();
                    chk("wr_addr", {496'd0, wr_addr_o}, {496'd0, e.addr});
                    chk("wr_data", wr_data_o, e.data);
                    chk("wr_mask", {496'd0, wr_mask_o}, {496'd0, e.mask});
                end
                last_wr_cyc = cyc;
            end
            held_prev = wr_en_o && !wr_rdy_i;
            prev_addr = wr_addr_o;
            prev_data = wr_data_o;
            prev_mask = wr_mask_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pushes the expected lines, pulses start, then feeds results honouring stall_o.
    task automatic run_job(input logic [15:0] base, input int n, input bit rnd, output int stall_at);
        logic [31:0]  vals[$];
        line_t        e;
        int           guard;
        stall_at = -1;
        for (int i = 0; i < n; i++) vals.push_back(rnd ? $urandom : 32'(i + 1));
        for (int l = 0; l < (n + 15) / 16; l++) begin
            e.addr = base + 16'(l);
            e.data = '0;
            e.mask = '0;
            for (int k = 0; k < 16; k++) begin
                if (l * 16 + k < n) begin
                    e.data[k*32 +: 32] = vals[l*16 + k];
                    e.mask[k] = 1'b1;
                end
            end
            sb.push_back(e);
        end
        start = 1'b1;
        base_addr = base;
        num_results = 16'(n);
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while (stall_o && guard < 300) begin
                if (stall_at < 0) stall_at = i;
                res_vld_i = 1'b0;
                step();
                guard++;
            end
            if (guard >= 300) chk("stall_timeout", 512'd1, 512'd0);
            res_vld_i = 1'b1;
            res_i = vals[i];
            step();
        end
        res_vld_i = 1'b0;
    endtask

    task automatic wait_done(input bit chk_lat);
        int guard = 0;
        while (!done_o && guard < 500) begin
            step();
            guard++;
        end
        chk("done_seen", {511'd0, done_o}, 512'd1);
        if (chk_lat) chk("done_latency", 512'(cyc), 512'(last_wr_cyc + 1));
        step();
        chk("done_one_cycle", {511'd0, done_o}, 512'd0);
        chk("idle_after_done", {511'd0, busy_o}, 512'd0);
        chk("sb_empty", 512'(sb.size()), 512'd0);
    endtask

    initial begin
        int st;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_results = '0;
        res_i = '0;
        res_vld_i = 1'b0;
        wr_rdy_i = 1'b1;
        repeat (3) step();
        chk("rst_wr_en", {511'd0, wr_en_o}, 512'd0);
        chk("rst_stall", {511'd0, stall_o}, 512'd0);
        chk("rst_busy", {511'd0, busy_o}, 512'd0);
        chk("rst_done", {511'd0, done_o}, 512'd0);
        chk("rst_ovf", {511'd0, ovf_err_o}, 512'd0);
        chk("rst_wr_data", {wr_data_o}, 512'd0);
        chk("rst_addr_mask", {480'd0, wr_addr_o, wr_mask_o}, 512'd0);
        rst_n = 1'b1;
        step();

        // One full line, lanes 1..16
        run_job(16'h0100, 16, 1'b0, st);
        chk("busy_in_job", {511'd0, busy_o}, 512'd1);
        wait_done(1'b1);

        // Partial second line
        run_job(16'h0200, 20, 1'b1, st);
        wait_done(1'b1);

        // Backpressure: sink blocked for 40 cycles
        wr_rdy_i = 1'b0;
        fork
            run_job(16'h0300, 48, 1'b1, st);
            begin
                repeat (40) step();
                wr_rdy_i = 1'b1;
            end
        join
        chk("stall_after_32", 512'(st), 512'd32);
        wait_done(1'b1);
        chk("no_ovf_backpressure", {511'd0, ovf_err_o}, 512'd0);

        // Result forced while stalled is dropped and flagged
        wr_rdy_i = 1'b0;
        run_job(16'h0400, 32, 1'b1, st);
        chk("stall_high", {511'd0, stall_o}, 512'd1);
        res_vld_i = 1'b1;
        res_i = 32'hDEAD_BEEF;
        step();
        res_vld_i = 1'b0;
        chk("ovf_set", {511'd0, ovf_err_o}, 512'd1);
        wr_rdy_i = 1'b1;
        wait_done(1'b1);
        chk("ovf_sticky", {511'd0, ovf_err_o}, 512'd1);

        // Empty job: no write, done pulse; start clears ovf
        run_job(16'h0500, 0, 1'b0, st);
        chk("ovf_cleared", {511'd0, ovf_err_o}, 512'd0);
        wait_done(1'b0);

        // Address wrap
        run_job(16'hFFFF, 32, 1'b1, st);
        wait_done(1'b1);

        // Reset mid-job while a write is held
        wr_rdy_i = 1'b0;
        run_job(16'h0040, 16, 1'b1, st);
        chk("wr_en_before_rst", {511'd0, wr_en_o}, 512'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", {511'd0, wr_en_o}, 512'd0);
        chk("midrst_data", wr_data_o, 512'd0);
        chk("midrst_addr_mask", {480'd0, wr_addr_o, wr_mask_o}, 512'd0);
        chk("midrst_flags", {508'd0, busy_o, done_o, stall_o, ovf_err_o}, 512'd0);
        sb.delete();
        wr_rdy_i = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        run_job(16'h0010, 5, 1'b1, st);
        wait_done(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
